// File: rtl/forward_scoreboard.sv
// Operand forwarding with a per-register scoreboard of in-flight writes.
// Resolves decode-stage rs/rt from prioritised forwarding taps or the register
// file, stalls when the newest value is not yet available, and counts stall cycles.
module forward_scoreboard #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_FWD        = 3,
  parameter int unsigned CNT_WIDTH      = 2,
  parameter int unsigned PERF_WIDTH     = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               issue_valid,
  input  logic                               issue_uses_rs,
  input  logic                               issue_uses_rt,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_rt_addr,
  input  logic                               issue_uses_rw,
  input  logic [REG_ADDR_WIDTH-1:0]          issue_rw_addr,
  input  logic [DATA_WIDTH-1:0]              rf_rs_data,
  input  logic [DATA_WIDTH-1:0]              rf_rt_data,
  input  logic [NUM_FWD-1:0]                 fwd_valid,
  input  logic [NUM_FWD-1:0]                 fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0]  fwd_addr,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]      fwd_data,
  input  logic                               retire_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          retire_addr,
  input  logic                               flush,
  output logic [DATA_WIDTH-1:0]              rs_data,
  output logic [DATA_WIDTH-1:0]              rt_data,
  output logic                               stall,
  output logic [PERF_WIDTH-1:0]              stall_cycles
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam int NUM_TAPS = int'(NUM_FWD);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0]      pend_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]      pend_d [NUM_REGS];
  logic [PERF_WIDTH-1:0]     stall_cycles_q;
  logic [PERF_WIDTH-1:0]     stall_cycles_d;

  // Operand 0 is rs, operand 1 is rt; both resolve through the same logic.
  logic                      op_uses  [2];
  logic [REG_ADDR_WIDTH-1:0] op_addr  [2];
  logic [DATA_WIDTH-1:0]     op_rf    [2];
  logic [DATA_WIDTH-1:0]     op_data  [2];
  logic                      op_stall [2];
  logic                      op_hit   [2];

  logic waw_stall;
  logic accept;
  logic inc;
  logic dec;

  assign op_uses[0] = issue_uses_rs;
  assign op_uses[1] = issue_uses_rt;
  assign op_addr[0] = issue_rs_addr;
  assign op_addr[1] = issue_rt_addr;
  assign op_rf[0]   = rf_rs_data;
  assign op_rf[1]   = rf_rt_data;

  // Operand resolution: youngest matching tap wins; unmatched or unready producer stalls.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      op_data[k]  = op_rf[k];
      op_stall[k] = 1'b0;
      op_hit[k]   = 1'b0;
      if (op_addr[k] == '0) begin
        op_data[k] = '0;
      end else if (op_uses[k] && (pend_q[op_addr[k]] != '0)) begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          if (!op_hit[k] && fwd_valid[i] &&
              (fwd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == op_addr[k])) begin
            op_hit[k] = 1'b1;
            if (fwd_ready[i]) op_data[k] = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
            else              op_stall[k] = 1'b1;
          end
        end
        if (!op_hit[k]) op_stall[k] = 1'b1;
      end
    end
  end

  assign waw_stall = issue_uses_rw && (issue_rw_addr != '0) &&
                     (pend_q[issue_rw_addr] == CNT_MAX);
  assign stall   = issue_valid && !flush && (op_stall[0] || op_stall[1] || waw_stall);
  assign accept  = issue_valid && !stall && !flush;
  assign inc     = accept && issue_uses_rw && (issue_rw_addr != '0);
  assign dec     = retire_valid && (retire_addr != '0) && !flush;
  assign rs_data = op_data[0];
  assign rt_data = op_data[1];
  assign stall_cycles = stall_cycles_q;

  // Scoreboard next state: flush clears everything, matched inc/dec cancel.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) pend_d[r] = pend_q[r];
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) pend_d[r] = '0;
    end else if (!(inc && dec && (issue_rw_addr == retire_addr))) begin
      if (inc) pend_d[issue_rw_addr] = pend_q[issue_rw_addr] + CNT_WIDTH'(1);
      if (dec && (pend_q[retire_addr] != '0))
        pend_d[retire_addr] = pend_q[retire_addr] - CNT_WIDTH'(1);
    end
    pend_d[0] = '0;
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {PERF_WIDTH{1'b1}}))
      stall_cycles_d = stall_cycles_q + PERF_WIDTH'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: directed scenarios followed by
// randomized traffic, all checked against a reference model of the scoreboard rules.
module tb_forward_scoreboard;

  localparam int DW   = 32;
  localparam int RAW  = 5;
  localparam int NF   = 3;
  localparam int CW   = 2;
  localparam int PW   = 32;
  localparam int NREG = 1 << RAW;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid, issue_uses_rs, issue_uses_rt, issue_uses_rw;
  logic [RAW-1:0]    issue_rs_addr, issue_rt_addr, issue_rw_addr;
  logic [DW-1:0]     rf_rs_data, rf_rt_data;
  logic [NF-1:0]     fwd_valid, fwd_ready;
  logic [NF*RAW-1:0] fwd_addr;
  logic [NF*DW-1:0]  fwd_data;
  logic              retire_valid;
  logic [RAW-1:0]    retire_addr;
  logic              flush;
  logic [DW-1:0]     rs_data, rt_data;
  logic              stall;
  logic [PW-1:0]     stall_cycles;

  int checks = 0;
  int errors = 0;
  int pend_m [NREG];
  longint stall_cnt_m = 0;

  forward_scoreboard #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .NUM_FWD(NF), .CNT_WIDTH(CW), .PERF_WIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
    .issue_rs_addr(issue_rs_addr), .issue_rt_addr(issue_rt_addr),
    .issue_uses_rw(issue_uses_rw), .issue_rw_addr(issue_rw_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retire_valid(retire_valid), .retire_addr(retire_addr), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_uses_rs = 0; issue_uses_rt = 0; issue_uses_rw = 0;
    issue_rs_addr = '0; issue_rt_addr = '0; issue_rw_addr = '0;
    rf_rs_data = '0; rf_rt_data = '0;
    fwd_valid = '0; fwd_ready = '0; fwd_addr = '0; fwd_data = '0;
    retire_valid = 0; retire_addr = '0; flush = 0;
  endtask

  task automatic set_tap(input int i, input logic v, input logic r,
                         input logic [RAW-1:0] a, input logic [DW-1:0] d);
    fwd_valid[i] = v;
    fwd_ready[i] = r;
    fwd_addr[i*RAW +: RAW] = a;
    fwd_data[i*DW +: DW] = d;
  endtask

  task automatic issue(input logic urs, input logic [RAW-1:0] rs, input logic urt,
                       input logic [RAW-1:0] rt, input logic urw, input logic [RAW-1:0] rw);
    issue_valid = 1; issue_uses_rs = urs; issue_rs_addr = rs;
    issue_uses_rt = urt; issue_rt_addr = rt; issue_uses_rw = urw; issue_rw_addr = rw;
  endtask

  // Reference: an operand needs a producer only if it is pending; the first
  // tap (program-order youngest) naming it decides between data and stall.
  function automatic void model_op(input logic uses, input logic [RAW-1:0] a,
                                   input logic [DW-1:0] rf,
                                   output logic [DW-1:0] d, output logic st);
    d = rf;
    st = 1'b0;
    if (a == 0) begin
      d = '0;
    end else if (uses && pend_m[a] > 0) begin
      int hit;
      hit = -1;
      for (int i = NF - 1; i >= 0; i--)
        if (fwd_valid[i] && fwd_addr[i*RAW +: RAW] == a) hit = i;
      if (hit < 0) st = 1'b1;
      else if (fwd_ready[hit]) d = fwd_data[hit*DW +: DW];
      else st = 1'b1;
    end
  endfunction

  function automatic void model_update(input logic est);
    logic acc, inc, dec;
    acc = issue_valid && !est && !flush;
    if (flush) begin
      for (int r = 0; r < NREG; r++) pend_m[r] = 0;
    end else begin
      inc = acc && issue_uses_rw && issue_rw_addr != 0;
      dec = retire_valid && retire_addr != 0;
      if (!(inc && dec && issue_rw_addr == retire_addr)) begin
        if (inc) pend_m[issue_rw_addr]++;
        if (dec && pend_m[retire_addr] > 0) pend_m[retire_addr]--;
      end
    end
    if (est && stall_cnt_m < 64'hFFFF_FFFF) stall_cnt_m++;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag);
    logic [DW-1:0] ers, ert;
    logic srs, srt, est;
    @(negedge clk);
    model_op(issue_uses_rs, issue_rs_addr, rf_rs_data, ers, srs);
    model_op(issue_uses_rt, issue_rt_addr, rf_rt_data, ert, srt);
    est = issue_valid && !flush &&
          (srs || srt || (issue_uses_rw && issue_rw_addr != 0 && pend_m[issue_rw_addr] == CMAX));
    check({tag, ".stall"}, 64'(stall), 64'(est));
    check({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(stall_cnt_m));
    if (!est) begin
      check({tag, ".rs"}, 64'(rs_data), 64'(ers));
      check({tag, ".rt"}, 64'(rt_data), 64'(ert));
    end
    @(posedge clk);
    if (rst_n) model_update(est);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    longint sc_before;
    for (int r = 0; r < NREG; r++) pend_m[r] = 0;
    rst_n = 0;
    clear_inputs();
    // Reset: pass-through, no stall, counter zero.
    issue(1, 5'd1, 1, 5'd2, 1, 5'd3);
    rf_rs_data = 32'h0BAD_F00D; rf_rt_data = 32'h1234_0000;
    step("reset0");
    step("reset1");
    rst_n = 1;

    // add $3 <- $1,$2 with no taps.
    rf_rs_data = 32'h11; rf_rt_data = 32'h22;
    step("add3");
    check("add3.rs_const", 64'(rs_data), 64'h11);
    // $3 now pending with no tap -> stall.
    issue(1, 5'd3, 0, 5'd0, 0, 5'd0);
    step("dep3_notap");
    // Youngest tap wins.
    set_tap(0, 1, 1, 5'd3, 32'hAAAA);
    set_tap(2, 1, 1, 5'd3, 32'hBBBB);
    step("dep3_taps");
    check("dep3_taps.rs_const", 64'(rs_data), 64'hAAAA);
    clear_inputs();
    retire_valid = 1; retire_addr = 5'd3;
    step("retire3");

    // Load to $5 then dependent issue held by unready tap for 4 cycles.
    clear_inputs();
    issue(0, 5'd0, 0, 5'd0, 1, 5'd5);
    step("load5");
    issue(1, 5'd5, 1, 5'd2, 0, 5'd0);
    rf_rt_data = 32'h77;
    set_tap(0, 1, 0, 5'd5, 32'h0);
    sc_before = stall_cnt_m;
    for (int c = 0; c < 4; c++) step("load5_wait");
    check("load5.stall_delta", 64'(stall_cycles) - 64'(sc_before), 64'd4);
    set_tap(0, 1, 1, 5'd5, 32'h1234);
    step("load5_ready");
    check("load5_ready.rs_const", 64'(rs_data), 64'h1234);
    clear_inputs();
    retire_valid = 1; retire_addr = 5'd5;
    step("retire5");

    // $7 produced outside the tap window until it retires.
    clear_inputs();
    issue(0, 5'd0, 0, 5'd0, 1, 5'd7);
    step("mul7");
    issue(0, 5'd0, 1, 5'd7, 0, 5'd0);
    rf_rt_data = 32'h7777;
    set_tap(1, 1, 1, 5'd8, 32'hDEAD);
    for (int c = 0; c < 3; c++) step("dep7_wait");
    retire_valid = 1; retire_addr = 5'd7;
    step("dep7_retire");
    retire_valid = 0;
    step("dep7_rf");
    check("dep7_rf.rt_const", 64'(rt_data), 64'h7777);

    // WAW saturation on $9.
    clear_inputs();
    issue(0, 5'd0, 0, 5'd0, 1, 5'd9);
    for (int c = 0; c < 3; c++) step("waw9_fill");
    step("waw9_sat");
    check("waw9_sat.stall_const", 64'(stall), 64'd1);
    retire_valid = 1; retire_addr = 5'd9;
    step("waw9_sat_retire");
    step("waw9_inc_dec");
    retire_valid = 0;
    step("waw9_refill");
    step("waw9_sat2");

    // Flush with same-cycle issue and retire.
    clear_inputs();
    retire_valid = 1; retire_addr = 5'd9;
    for (int c = 0; c < 3; c++) step("drain9");
    clear_inputs();
    issue(0, 5'd0, 0, 5'd0, 1, 5'd4);
    step("w4a");
    step("w4b");
    issue(0, 5'd0, 0, 5'd0, 1, 5'd6);
    step("w6");
    issue(0, 5'd0, 0, 5'd0, 1, 5'd4);
    retire_valid = 1; retire_addr = 5'd6;
    flush = 1;
    step("flush");
    clear_inputs();
    issue(1, 5'd4, 1, 5'd6, 0, 5'd0);
    rf_rs_data = 32'h44; rf_rt_data = 32'h66;
    step("post_flush");
    check("post_flush.stall_const", 64'(stall), 64'd0);

    // Randomized traffic over a small register window.
    for (int c = 0; c < 400; c++) begin
      int r;
      clear_inputs();
      issue_valid   = ($urandom_range(0, 3) != 0);
      issue_uses_rs = $urandom_range(0, 1);
      issue_uses_rt = $urandom_range(0, 1);
      issue_uses_rw = $urandom_range(0, 1);
      issue_rs_addr = RAW'($urandom_range(0, 7));
      issue_rt_addr = RAW'($urandom_range(0, 7));
      issue_rw_addr = RAW'($urandom_range(0, 7));
      rf_rs_data = $urandom;
      rf_rt_data = $urandom;
      for (int i = 0; i < NF; i++)
        set_tap(i, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                RAW'($urandom_range(0, 7)), $urandom);
      r = $urandom_range(1, 7);
      if (pend_m[r] > 0 && $urandom_range(0, 1) == 1) begin
        retire_valid = 1; retire_addr = RAW'(r);
      end else if ($urandom_range(0, 9) == 0) begin
        retire_valid = 1; retire_addr = RAW'($urandom_range(0, 7));
      end
      flush = ($urandom_range(0, 39) == 0);
      step("rand");
    end

    // Asynchronous reset mid-operation.
    clear_inputs();
    issue(0, 5'd0, 0, 5'd0, 1, 5'd12);
    step("pre_rst_w12");
    issue(1, 5'd12, 0, 5'd0, 0, 5'd0);
    rf_rs_data = 32'hC0C0;
    step("pre_rst_dep12");
    #2;
    rst_n = 0;
    #1;
    for (int r = 0; r < NREG; r++) pend_m[r] = 0;
    stall_cnt_m = 0;
    check("async_rst.stall_cycles", 64'(stall_cycles), 64'd0);
    check("async_rst.stall", 64'(stall), 64'd0);
    check("async_rst.rs", 64'(rs_data), 64'hC0C0);
    step("in_rst");
    rst_n = 1;
    step("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
